// File: rtl/pend_ctr.sv
// Pending-write counter for one register: counts reservations minus writebacks,
// holds at its limits and flags the offending request instead of wrapping.
module pend_ctr #(
    parameter int W_PEND = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              inc,
    input  logic              dec,
    output logic [W_PEND-1:0] cnt,
    output logic              full,
    output logic              err
);
    localparam logic [W_PEND-1:0] CNT_MAX = '1;

    logic [W_PEND-1:0] cnt_reg;
    logic [W_PEND-1:0] cnt_next;
    logic              ovf;
    logic              unf;

    always_comb begin
        // A writeback landing this cycle frees a slot, so it is not full then.
        full     = (cnt_reg == CNT_MAX) && !dec;
        ovf      = inc && full;
        unf      = dec && !inc && (cnt_reg == '0);
        err      = ovf || unf;
        cnt_next = cnt_reg;
        if (inc && !dec && !ovf)
            cnt_next = cnt_reg + 1'b1;
        else if (dec && !inc && !unf)
            cnt_next = cnt_reg - 1'b1;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            cnt_reg <= '0;
        else
            cnt_reg <= cnt_next;
    end

    assign cnt = cnt_reg;
endmodule

// File: rtl/regfile_sb.sv
// Register file with write-through read bypass and per-register pending-write
// scoreboard; raises reserved_o so decode can stall on read-after-write hazards.
module regfile_sb #(
    parameter int WORD   = 32,
    parameter int W_RN   = 3,
    parameter int NREG   = 2 ** W_RN,
    parameter int W_PEND = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [W_RN-1:0] r0_num_i,
    input  logic [W_RN-1:0] r1_num_i,
    output logic [WORD-1:0] r0_data_o,
    output logic [WORD-1:0] r1_data_o,
    input  logic            w_reserve_i,
    output logic            reserved_o,
    input  logic            wb_v_i,
    input  logic [W_RN-1:0] wb_num_i,
    input  logic [WORD-1:0] wb_data_i,
    output logic            full_o,
    output logic            err_o
);
    logic [WORD-1:0]   regs_reg [NREG];
    logic [W_PEND-1:0] pend_cnt [NREG];
    logic [NREG-1:0]   pend_inc;
    logic [NREG-1:0]   pend_dec;
    logic [NREG-1:0]   pend_full;
    logic [NREG-1:0]   pend_err;
    logic [NREG-1:0]   busy;
    logic              err_reg;

    genvar gi;
    generate
        for (gi = 0; gi < NREG; gi++) begin : g_reg
            assign pend_inc[gi] = w_reserve_i && (r0_num_i == W_RN'(gi));
            assign pend_dec[gi] = wb_v_i && (wb_num_i == W_RN'(gi));
            // Effective count excludes a writeback arriving this cycle, so the
            // stall releases with zero bubbles.
            assign busy[gi] = (pend_cnt[gi] != {{(W_PEND-1){1'b0}}, pend_dec[gi]});

            pend_ctr #(.W_PEND(W_PEND)) u_pend (
                .clk  (clk),
                .rst  (rst),
                .inc  (pend_inc[gi]),
                .dec  (pend_dec[gi]),
                .cnt  (pend_cnt[gi]),
                .full (pend_full[gi]),
                .err  (pend_err[gi])
            );

            always_ff @(posedge clk or negedge rst) begin
                if (!rst)
                    regs_reg[gi] <= '0;
                else if (pend_dec[gi])
                    regs_reg[gi] <= wb_data_i;
            end
        end
    endgenerate

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            err_reg <= 1'b0;
        else if (|pend_err)
            err_reg <= 1'b1;
    end

    always_comb begin
        r0_data_o = (wb_v_i && wb_num_i == r0_num_i) ? wb_data_i : regs_reg[r0_num_i];
        r1_data_o = (wb_v_i && wb_num_i == r1_num_i) ? wb_data_i : regs_reg[r1_num_i];
    end

    assign reserved_o = busy[r0_num_i] || busy[r1_num_i];
    assign full_o     = pend_full[r0_num_i];
    assign err_o      = err_reg;
endmodule

// File: tb/tb_regfile_sb.sv
// Directed-vector bench for regfile_sb: bypass/array reads, scoreboard stall
// and release, counter limits, sticky error and asynchronous reset.
module tb_regfile_sb;
    logic        clk;
    logic        rst;
    logic [2:0]  r0_num_i;
    logic [2:0]  r1_num_i;
    logic [31:0] r0_data_o;
    logic [31:0] r1_data_o;
    logic        w_reserve_i;
    logic        reserved_o;
    logic        wb_v_i;
    logic [2:0]  wb_num_i;
    logic [31:0] wb_data_i;
    logic        full_o;
    logic        err_o;

    int n_vec;
    int n_miss;

    regfile_sb dut (
        .clk         (clk),
        .rst         (rst),
        .r0_num_i    (r0_num_i),
        .r1_num_i    (r1_num_i),
        .r0_data_o   (r0_data_o),
        .r1_data_o   (r1_data_o),
        .w_reserve_i (w_reserve_i),
        .reserved_o  (reserved_o),
        .wb_v_i      (wb_v_i),
        .wb_num_i    (wb_num_i),
        .wb_data_i   (wb_data_i),
        .full_o      (full_o),
        .err_o       (err_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end else begin
            $display("ok   %s: %h", tag, got);
        end
    endtask

    // Advance to just after the next rising edge and return inputs to idle.
    task automatic cyc();
        @(posedge clk);
        #1;
        w_reserve_i = 1'b0;
        wb_v_i      = 1'b0;
        wb_num_i    = '0;
        wb_data_i   = '0;
    endtask

    task automatic settle();
        #1;
    endtask

    initial begin
        n_vec = 0;
        n_miss = 0;
        rst = 1'b0;
        r0_num_i = 3'd3;
        r1_num_i = 3'd5;
        w_reserve_i = 1'b0;
        wb_v_i = 1'b0;
        wb_num_i = '0;
        wb_data_i = '0;
        #12 rst = 1'b1;

        // Reset state
        cyc();
        settle();
        chk("rst_r0_data", r0_data_o, 32'h0);
        chk("rst_r1_data", r1_data_o, 32'h0);
        chk("rst_reserved", {31'b0, reserved_o}, 32'h0);
        chk("rst_full", {31'b0, full_o}, 32'h0);
        chk("rst_err", {31'b0, err_o}, 32'h0);

        // Reserve r2, then write it back with r0 pointing at it (bypass)
        r0_num_i = 3'd2; w_reserve_i = 1'b1;
        cyc();
        settle();
        chk("r2_reserved", {31'b0, reserved_o}, 32'h1);
        wb_v_i = 1'b1; wb_num_i = 3'd2; wb_data_i = 32'hDEADBEEF;
        settle();
        chk("r2_bypass", r0_data_o, 32'hDEADBEEF);
        chk("r2_release", {31'b0, reserved_o}, 32'h0);
        cyc();
        settle();
        chk("r2_array", r0_data_o, 32'hDEADBEEF);
        chk("r2_no_err", {31'b0, err_o}, 32'h0);

        // Reserve r4, stall on r1, zero-bubble release on writeback
        r0_num_i = 3'd4; w_reserve_i = 1'b1;
        cyc();
        r0_num_i = 3'd0; r1_num_i = 3'd4;
        settle();
        chk("r4_stall", {31'b0, reserved_o}, 32'h1);
        cyc();
        wb_v_i = 1'b1; wb_num_i = 3'd4; wb_data_i = 32'h12345678;
        settle();
        chk("r4_release", {31'b0, reserved_o}, 32'h0);
        chk("r4_bypass_r1", r1_data_o, 32'h12345678);

        // Fill r6 to the limit, then overflow
        cyc();
        r0_num_i = 3'd6; r1_num_i = 3'd0;
        for (int i = 0; i < 3; i++) begin
            w_reserve_i = 1'b1;
            settle();
            chk($sformatf("r6_notfull_%0d", i), {31'b0, full_o}, 32'h0);
            cyc();
        end
        settle();
        chk("r6_full", {31'b0, full_o}, 32'h1);
        chk("r6_no_err_yet", {31'b0, err_o}, 32'h0);
        w_reserve_i = 1'b1;
        cyc();
        settle();
        chk("r6_ovf_err", {31'b0, err_o}, 32'h1);
        chk("r6_still_full", {31'b0, full_o}, 32'h1);
        for (int i = 0; i < 3; i++) begin
            wb_v_i = 1'b1; wb_num_i = 3'd6; wb_data_i = 32'h6600_0000 + i;
            settle();
            chk($sformatf("r6_wb%0d_reserved", i), {31'b0, reserved_o}, (i == 2) ? 32'h0 : 32'h1);
            chk($sformatf("r6_wb%0d_full", i), {31'b0, full_o}, 32'h0);
            cyc();
        end
        settle();
        chk("r6_array", r0_data_o, 32'h6600_0002);
        chk("r6_idle_reserved", {31'b0, reserved_o}, 32'h0);

        // Asynchronous reset mid-cycle, with r4 reserved again
        r0_num_i = 3'd4; w_reserve_i = 1'b1;
        cyc();
        r0_num_i = 3'd6; r1_num_i = 3'd4;
        settle();
        chk("pre_rst_reserved", {31'b0, reserved_o}, 32'h1);
        rst = 1'b0;
        settle();
        chk("async_rst_r0", r0_data_o, 32'h0);
        chk("async_rst_r1", r1_data_o, 32'h0);
        chk("async_rst_reserved", {31'b0, reserved_o}, 32'h0);
        chk("async_rst_err", {31'b0, err_o}, 32'h0);
        settle();
        rst = 1'b1;

        // Reserve r1, then reserve and write back r1 together
        cyc();
        r0_num_i = 3'd1; r1_num_i = 3'd0; w_reserve_i = 1'b1;
        cyc();
        w_reserve_i = 1'b1; wb_v_i = 1'b1; wb_num_i = 3'd1; wb_data_i = 32'hAAAA5555;
        settle();
        chk("r1_same_cycle_reserved", {31'b0, reserved_o}, 32'h0);
        cyc();
        settle();
        chk("r1_still_pending", {31'b0, reserved_o}, 32'h1);
        chk("r1_data", r0_data_o, 32'hAAAA5555);
        chk("r1_no_err", {31'b0, err_o}, 32'h0);
        wb_v_i = 1'b1; wb_num_i = 3'd1; wb_data_i = 32'h1111_2222;
        cyc();
        settle();
        chk("r1_cleared", {31'b0, reserved_o}, 32'h0);
        chk("r1_clear_no_err", {31'b0, err_o}, 32'h0);

        // Underflow: writeback to r7 with nothing pending
        r0_num_i = 3'd7; r1_num_i = 3'd7;
        wb_v_i = 1'b1; wb_num_i = 3'd7; wb_data_i = 32'h0BADF00D;
        settle();
        chk("r7_bypass", r0_data_o, 32'h0BADF00D);
        cyc();
        settle();
        chk("r7_written", r0_data_o, 32'h0BADF00D);
        chk("r7_same_port", r1_data_o, 32'h0BADF00D);
        chk("r7_unf_err", {31'b0, err_o}, 32'h1);
        cyc();
        settle();
        chk("r7_err_sticky", {31'b0, err_o}, 32'h1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end
endmodule
